// File: rtl/piso_serializer_if.sv
// Valid/ready word handshake into the serializer plus its serial output toward the "101" detector.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             word_done;

  modport master (
    output din, din_valid,
    input  din_ready, x, x_valid, busy, word_done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, x, x_valid, busy, word_done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage with a one-word holding register for gapless streaming.
// Optional macro PISO_LSB_FIRST_EN selects LSB-first serialization (default MSB first).
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  piso_serializer_if.slave  bus
);
  localparam int              CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST    = CW'(WIDTH - 1);
  localparam logic [0:0]      S_IDLE  = 1'b0;
  localparam logic [0:0]      S_SHIFT = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic             r_x;
  logic             r_x_valid;
  logic             r_word_done;
  logic             r_busy;

  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] w_sreg_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_hold_nxt;
  logic             w_hold_full_nxt;
  logic             w_ready;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_shifted;
  logic             w_bit_nxt;

  assign w_ready  = !r_hold_full && !rst;
  assign w_accept = bus.din_valid && w_ready;
  assign w_last   = (r_cnt == LAST);

`ifdef PISO_LSB_FIRST_EN
  assign w_shifted = {1'b0, r_sreg[WIDTH-1:1]};
  assign w_bit_nxt = w_sreg_nxt[0];
`else
  assign w_shifted = {r_sreg[WIDTH-2:0], 1'b0};
  assign w_bit_nxt = w_sreg_nxt[WIDTH-1];
`endif

  // Next-state: sreg always holds the bit currently on x at its output end.
  always_comb begin
    w_state_nxt     = r_state;
    w_sreg_nxt      = r_sreg;
    w_cnt_nxt       = r_cnt;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_sreg_nxt  = bus.din;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          if (r_hold_full) begin
            w_sreg_nxt      = r_hold;
            w_hold_full_nxt = 1'b0;
            w_cnt_nxt       = '0;
          end else if (w_accept) begin
            w_sreg_nxt = bus.din;
            w_cnt_nxt  = '0;
          end else begin
            w_sreg_nxt  = w_shifted;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_sreg_nxt = w_shifted;
          w_cnt_nxt  = r_cnt + CW'(1);
          if (w_accept) begin
            w_hold_nxt      = bus.din;
            w_hold_full_nxt = 1'b1;
          end else begin
            w_hold_full_nxt = r_hold_full;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; outputs are computed from next-state so x leads by no cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sreg      <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_x         <= 1'b0;
      r_x_valid   <= 1'b0;
      r_word_done <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sreg      <= w_sreg_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_x         <= (w_state_nxt == S_SHIFT) && w_bit_nxt;
      r_x_valid   <= (w_state_nxt == S_SHIFT);
      r_word_done <= (w_state_nxt == S_SHIFT) && (w_cnt_nxt == LAST);
      r_busy      <= (w_state_nxt == S_SHIFT) || w_hold_full_nxt;
    end
  end

  assign bus.din_ready = w_ready;
  assign bus.x         = r_x;
  assign bus.x_valid   = r_x_valid;
  assign bus.word_done = r_word_done;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: expected bits queued at accept, popped by a negedge monitor.
module tb_piso_serializer;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [1:0] exp_q[$];   // {bit, last}
  logic [2:0] det_hist;
  int   det_n;
  int   det_cnt;

  piso_serializer_if #(.WIDTH(8)) bus ();

  piso_serializer #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every valid bit against the queue and runs a model "101" detector.
  always @(negedge clk) begin
    logic [1:0] e;
    if (bus.x_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bit", 32'(bus.x_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("x_bit", 32'(bus.x), 32'(e[1]));
        chk("word_done", 32'(bus.word_done), 32'(e[0]));
      end
      det_hist = {det_hist[1:0], bus.x};
      det_n++;
      if (det_n >= 3 && det_hist == 3'b101) det_cnt++;
    end else begin
      chk("idle_x_wd", {30'd0, bus.x, bus.word_done}, 32'd0);
      if (exp_q.size() != 0) chk("stream_gap", 32'(bus.x_valid), 32'd1);
    end
  end

  task automatic push_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
`ifdef PISO_LSB_FIRST_EN
      exp_q.push_back({w[i], (i == 7) ? 1'b1 : 1'b0});
`else
      exp_q.push_back({w[7-i], (i == 7) ? 1'b1 : 1'b0});
`endif
    end
  endtask

  // Present a word, wait (bounded) for din_ready, queue its bits at the accepting edge.
  task automatic send(input logic [7:0] w);
    int t;
    t = 0;
    bus.din = w;
    bus.din_valid = 1'b1;
    while (bus.din_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) chk("accept_timeout", 32'(t), 32'd0);
    @(posedge clk);
    push_word(w);
    #1;
    bus.din_valid = 1'b0;
    bus.din = 8'h00;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.busy === 1'b1 || bus.x_valid === 1'b1) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) chk("drain_timeout", 32'(t), 32'd0);
    chk("idle_x_valid", 32'(bus.x_valid), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    det_hist = 3'b000; det_n = 0; det_cnt = 0;
    rst = 1'b1;
    bus.din = 8'h3C;
    bus.din_valid = 1'b1;   // must be ignored during reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x_valid", 32'(bus.x_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_word_done", 32'(bus.word_done), 32'd0);
    chk("rst_x", 32'(bus.x), 32'd0);
    chk("rst_din_ready", 32'(bus.din_ready), 32'd0);
    bus.din_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.din_ready), 32'd1);

    // Single word
    send(8'hA5);
    wait_idle();

    // Back-to-back with hold; ready low until the first word's last bit has gone
    send(8'hA5);
    send(8'h5A);
    chk("b2b_ready_low", 32'(bus.din_ready), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("b2b_ready_low", 32'(bus.din_ready), 32'd0);
    end
    @(posedge clk); #1;
    chk("b2b_ready_back", 32'(bus.din_ready), 32'd1);
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    wait_idle();

    // Hold full: third word waits for the hold to drain
    send(8'hFF);
    send(8'h00);
    send(8'h81);
    wait_idle();

    // Reset mid-word after the third bit
    send(8'hF0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    exp_q.delete();
    #1;
    chk("midrst_x_valid", 32'(bus.x_valid), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_ready", 32'(bus.din_ready), 32'd0);
    rst = 1'b0;
    #1;
    send(8'h0F);
    wait_idle();

    // Detector integration: AA AA contains 7 overlapping "101"
    det_hist = 3'b000; det_n = 0; det_cnt = 0;
    send(8'hAA);
    send(8'hAA);
    wait_idle();
`ifdef PISO_LSB_FIRST_EN
    chk("det_count", 32'(det_cnt), 32'd7);   // 0101.. reversed still yields 7
`else
    chk("det_count", 32'(det_cnt), 32'd7);
`endif

    // Bit-order check word
    send(8'h01);
    wait_idle();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
